prog_rom_loader: RTL and testbench

// - Instruction-memory responder for the 4-bit core. Returns data_t {opcode[7:4], imm[3:0]} for the core's fetch address.
// - 16 x 8-bit register-file program store, rewritable at run time through a nibble-wide valid/ready loader.
// - Holds the core in reset while loading, then releases it once the checksum matches.
// - Sits between the board-level switch/host interface and the core's addr/data ports.

---
 rtl/prog_rom_loader_pkg.sv | 36 +++
 rtl/prog_rom_loader_mem.sv | 39 +++
 rtl/prog_rom_loader.sv | 143 ++++++++++++++
 tb/tb_prog_rom_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_rom_loader_pkg.sv
// Shared types for the 4-bit core's instruction store and its nibble-wide program loader.
package prog_rom_loader_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned DATA_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] imm;
    } data_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_JMP = 4'hF;

    // ADD A,0 behaves as a no-op, so a cleared store is harmless to execute.
    localparam data_t NOP_WORD = '{opcode: OP_ADD, imm: 4'h0};

    typedef enum logic [2:0] {
        ST_RUN,
        ST_LD_HI,
        ST_LD_LO,
        ST_CK_HI,
        ST_CK_LO,
        ST_HOLD,
        ST_ERR
    } loader_state_t;

    function automatic logic accepts_nibbles(loader_state_t s);
        return (s == ST_LD_HI) || (s == ST_LD_LO) || (s == ST_CK_HI) || (s == ST_CK_LO);
    endfunction

endpackage

// File: rtl/prog_rom_loader_mem.sv
// 16x8 program register file: async clear, one write port, one combinational read port.
module prog_mem
    import prog_rom_loader_pkg::*;
#(
    parameter int unsigned WORDS = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata
);

    data_t mem_q [WORDS];
    data_t mem_d [WORDS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = data_t'(wdata);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(WORDS); i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read sees the pre-write word during a same-cycle write.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_rom_loader.sv
// Instruction store for the 4-bit core with a checksummed nibble loader that holds the core in reset.
module prog_rom_loader
    import prog_rom_loader_pkg::*;
#(
    parameter int unsigned WORDS    = 16,
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  fetch_addr,
    output logic [7:0]  fetch_data,
    input  logic        prog_start,
    input  logic [3:0]  prog_nibble,
    input  logic        prog_valid,
    output logic        prog_ready,
    output logic        cpu_reset_n,
    output logic        load_busy,
    output logic        load_err
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    loader_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]  sum_q, sum_d;
    logic [NIB_W-1:0]   hi_q, hi_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               prog_ready_q, prog_ready_d;
    logic               cpu_reset_n_q, cpu_reset_n_d;
    logic               load_busy_q, load_busy_d;
    logic               load_err_q, load_err_d;

    logic               xfer_c;
    logic               mem_we_c;
    data_t              word_c;

    assign xfer_c = prog_valid && prog_ready_q;
    assign word_c = '{opcode: hi_q, imm: prog_nibble};

    // Next-state, counters, checksum and registered-output decode.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        sum_d      = sum_q;
        hi_d       = hi_q;
        hold_cnt_d = hold_cnt_q;
        mem_we_c   = 1'b0;

        if (prog_start) begin
            state_d    = ST_LD_HI;
            word_cnt_d = '0;
            sum_d      = '0;
        end else begin
            case (state_q)
                ST_LD_HI: begin
                    if (xfer_c) begin
                        hi_d    = prog_nibble;
                        state_d = ST_LD_LO;
                    end
                end
                ST_LD_LO: begin
                    if (xfer_c) begin
                        mem_we_c = 1'b1;
                        sum_d    = sum_q + DATA_W'(word_c);
                        if (word_cnt_q == ADDR_W'(WORDS - 1)) begin
                            state_d = ST_CK_HI;
                        end else begin
                            word_cnt_d = word_cnt_q + ADDR_W'(1);
                            state_d    = ST_LD_HI;
                        end
                    end
                end
                ST_CK_HI: begin
                    if (xfer_c) begin
                        hi_d    = prog_nibble;
                        state_d = ST_CK_LO;
                    end
                end
                ST_CK_LO: begin
                    if (xfer_c) begin
                        hold_cnt_d = '0;
                        state_d    = (DATA_W'(word_c) == sum_q) ? ST_HOLD : ST_ERR;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(HOLD_CYC - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end

        prog_ready_d  = accepts_nibbles(state_d);
        load_busy_d   = accepts_nibbles(state_d) || (state_d == ST_HOLD);
        cpu_reset_n_d = (state_d == ST_RUN);
        load_err_d    = (state_d == ST_ERR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            word_cnt_q    <= '0;
            sum_q         <= '0;
            hi_q          <= '0;
            hold_cnt_q    <= '0;
            prog_ready_q  <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            load_busy_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            sum_q         <= sum_d;
            hi_q          <= hi_d;
            hold_cnt_q    <= hold_cnt_d;
            prog_ready_q  <= prog_ready_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            load_busy_q   <= load_busy_d;
            load_err_q    <= load_err_d;
        end
    end

    prog_mem #(
        .WORDS (WORDS)
    ) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we_c),
        .waddr (word_cnt_q),
        .wdata (DATA_W'(word_c)),
        .raddr (addr_t'(fetch_addr)),
        .rdata (fetch_data)
    );

    assign prog_ready  = prog_ready_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign load_busy   = load_busy_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Scoreboard bench for prog_rom_loader: random loads against an array model of the program store.
module tb_prog_rom_loader;

    localparam int HOLD = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       prog_start;
    logic [3:0] prog_nibble;
    logic       prog_valid;
    logic       prog_ready;
    logic       cpu_reset_n;
    logic       load_busy;
    logic       load_err;

    prog_rom_loader #(.WORDS(16), .HOLD_CYC(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .prog_start  (prog_start),
        .prog_nibble (prog_nibble),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .cpu_reset_n (cpu_reset_n),
        .load_busy   (load_busy),
        .load_err    (load_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit err;
        int lat;
    } outcome_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_xcyc = 0;
    outcome_t   exp_q[$];
    logic [7:0] fetch_q[$];
    bit         fetch_req = 0;
    bit         in_load = 0;
    bit         busy_prev = 0;
    bit         tog = 0;
    logic [7:0] model_mem [16];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected fetch words and load outcomes whenever the DUT presents them.
    always @(negedge clock) begin : monitor
        logic [7:0] e;
        outcome_t   o;
        if (fetch_req) begin
            if (fetch_q.size() == 0) begin
                chk("fetch_queue_empty", 32'd1, 32'd0);
            end else begin
                e = fetch_q.pop_front();
                chk("fetch_data", 32'(fetch_data), 32'(e));
            end
            fetch_req = 0;
        end
        if (in_load) begin
            chk("busy_during_load", 32'(load_busy), 32'd1);
            chk("core_held_during_load", 32'(cpu_reset_n), 32'd0);
        end
        if (!reset && busy_prev && !load_busy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_load_end", 32'd1, 32'd0);
            end else begin
                o = exp_q.pop_front();
                chk("end_load_err", 32'(load_err), 32'(o.err));
                chk("end_cpu_reset_n", 32'(cpu_reset_n), 32'(!o.err));
                chk("end_latency", 32'(cyc - last_xcyc), 32'(o.lat));
            end
        end
        busy_prev = load_busy;
    end

    task automatic fetch_chk(input int a);
        fetch_addr = 4'(a);
        fetch_q.push_back(model_mem[a]);
        fetch_req = 1;
        @(posedge clock); #1;
    endtask

    task automatic fetch_all();
        for (int a = 0; a < 16; a++) fetch_chk(a);
    endtask

    // mode 0: always valid; 1: valid toggles every cycle; 2: random gaps.
    task automatic send_nib(input logic [3:0] n, input int mode, output int xcyc);
        bit acc = 0;
        bit v;
        int tries = 0;
        while (!acc && tries < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin tog = ~tog; v = tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            prog_valid  = v;
            prog_nibble = v ? n : 4'($urandom);
            @(negedge clock);
            acc = prog_valid && prog_ready;
            @(posedge clock); #1;
            tries++;
        end
        prog_valid = 1'b0;
        if (!acc) chk("nibble_accept_timeout", 32'd0, 32'd1);
        xcyc = cyc;
    endtask

    // A junk nibble offered alongside prog_start must be dropped.
    task automatic start_load(input bit junk);
        prog_start  = 1'b1;
        prog_valid  = junk;
        prog_nibble = 4'($urandom);
        @(posedge clock); #1;
        prog_start = 1'b0;
        prog_valid = 1'b0;
    endtask

    function automatic logic [7:0] csum(input logic [7:0] w[16]);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(w[i]);
        return 8'(s % 256);
    endfunction

    task automatic do_load(input logic [7:0] w[16], input logic [7:0] cks, input int mode,
                           input int stop_after);
        int xc;
        bit bad;
        start_load(mode != 0);
        in_load = 1;
        for (int i = 0; i < 16; i++) begin
            if (i == stop_after) return;
            send_nib(w[i][7:4], mode, xc);
            send_nib(w[i][3:0], mode, xc);
            model_mem[i] = w[i];
        end
        bad = (csum(w) != cks);
        exp_q.push_back('{err: bad, lat: bad ? 0 : HOLD});
        send_nib(cks[7:4], mode, xc);
        send_nib(cks[3:0], mode, xc);
        last_xcyc = xc;
        in_load = 0;
        repeat (HOLD + 2) @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] w[16];
        logic [7:0] r[16];

        reset = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_nibble = '0; fetch_addr = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("rst_prog_ready", 32'(prog_ready), 32'd0);
        chk("rst_load_busy", 32'(load_busy), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        fetch_all();
        reset = 1'b0;
        #1;
        chk("cpu_reset_n_before_first_edge", 32'(cpu_reset_n), 32'd0);
        @(posedge clock); #1;
        chk("cpu_reset_n_after_first_edge", 32'(cpu_reset_n), 32'd1);

        // Full good load of i*0x11, checksum 0xF8.
        for (int i = 0; i < 16; i++) w[i] = 8'(i * 8'h11);
        do_load(w, 8'hF8, 0, -1);
        chk("good_load_running", 32'(cpu_reset_n), 32'd1);
        chk("good_load_no_err", 32'(load_err), 32'd0);
        fetch_chk(5);
        fetch_all();

        // Same image, wrong checksum: core must stay in reset.
        do_load(w, 8'hF7, 2, -1);
        repeat (4) @(posedge clock);
        #1;
        chk("err_core_still_held", 32'(cpu_reset_n), 32'd0);
        chk("err_sticky", 32'(load_err), 32'd1);
        fetch_all();
        start_load(1'b0);
        chk("start_clears_err", 32'(load_err), 32'd0);
        chk("start_sets_busy", 32'(load_busy), 32'd1);
        chk("start_sets_ready", 32'(prog_ready), 32'd1);

        // Randomised good loads under backpressure.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
            do_load(r, csum(r), (k % 2) + 1, -1);
            fetch_all();
        end

        // Restart after word 7 keeps words 8..15 until they are rewritten.
        for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
        do_load(r, 8'h00, 2, 8);
        fetch_all();
        for (int i = 0; i < 16; i++) r[i] = 8'($urandom);
        do_load(r, csum(r), 1, -1);
        fetch_all();

        // Async reset while in LD_LO.
        start_load(1'b0);
        in_load = 1;
        begin
            int xc;
            for (int i = 0; i < 3; i++) begin
                send_nib(r[i][7:4], 0, xc);
                send_nib(~r[i][3:0], 0, xc);
                model_mem[i] = {r[i][7:4], ~r[i][3:0]};
            end
            send_nib(4'hA, 0, xc);
        end
        in_load = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("async_prog_ready", 32'(prog_ready), 32'd0);
        chk("async_load_busy", 32'(load_busy), 32'd0);
        chk("async_load_err", 32'(load_err), 32'd0);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        for (int a = 0; a < 4; a++) begin
            fetch_addr = 4'(a);
            #1;
            chk("async_mem_cleared", 32'(fetch_data), 32'd0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_reset_running", 32'(cpu_reset_n), 32'd1);
        fetch_all();

        chk("scoreboard_drained", 32'(exp_q.size() + fetch_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
